q_tx_serializer: RTL and testbench
==================================

Name: q_tx_serializer

Overview:
- Downstream neighbour of the modular multiplier core.
- Captures the 256-bit result Q on the core's out_valid pulse and serializes it as 32 bytes over a UART Tx line (8N1, LSB-first bits).
- Closes the Rx→multiply→Tx loop, so board-level results can be read back without the ILA.
- Holds one result at a time; back-pressures the producer with in_ready while sending.

Parameters:
- Q_WIDTH, 256, result width in bits; must be a multiple of 8.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 2.
- MSB_BYTE_FIRST, 1, 1 = byte Q[Q_WIDTH-1 -: 8] sent first; 0 = Q[7:0] sent first.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  result valid; driven by the multiplier's out_valid.
- Q  in  Q_WIDTH  result word; sampled only when in_valid && in_ready.
- in_ready  out  1  block idle and able to accept a result.
- Tx  out  1  UART serial output; idle high.
- busy  out  1  high from capture until the last stop bit completes.
- tx_done  out  1  one-cycle pulse after the final stop bit of the final byte.

Behaviour:
- Reset (reset=0, async assert, sync deassert by the system): Tx=1, in_ready=1, busy=0, tx_done=0, state=IDLE, shift register and all counters cleared.
- FSM states: IDLE, START, DATA, STOP, NEXT.
- IDLE: in_ready=1. On in_valid=1, latch Q into the shift register, set byte_cnt=0, go to START. in_ready drops the next cycle.
- START: Tx=0 for CLKS_PER_BIT cycles, then DATA with bit_cnt=0.
- DATA: Tx = current byte bit[bit_cnt], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP: Tx=1 for CLKS_PER_BIT cycles, then NEXT.
- NEXT (1 cycle): shift the register by 8 in the configured direction and increment byte_cnt.
  - If byte_cnt was Q_WIDTH/8-1: pulse tx_done, go to IDLE.
  - Otherwise go to START.
- Frame length per byte: 10*CLKS_PER_BIT + 1 cycles, including NEXT.
- Total latency from capture to tx_done: (Q_WIDTH/8)*(10*CLKS_PER_BIT+1) cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; bit transitions occur on the wrap.
- busy = (state != IDLE). in_ready = !busy.
- in_valid while busy: ignored (no capture, no error). The producer must hold or re-present the result.
- in_valid in the same cycle tx_done pulses: not accepted, because the block is still in NEXT. Acceptance is earliest the following cycle.
- Q changing while busy: no effect; data comes from the latched copy.
- Reset mid-frame: Tx returns high immediately (asynchronous) and the partial frame is abandoned.
- Byte and bit counters are sized $clog2(Q_WIDTH/8) and 3 bits respectively, with no overflow beyond the terminal count.

Optional Feature:
- Macro: Q_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving 8E1 framing of 11*CLKS_PER_BIT+1 cycles per byte.
- Undefined: 8N1 as above, and the PARITY state and its logic are absent.

Decomposition:
- Shared package q_tx_pkg:
  - FSM state enum (3 bits).
  - Constants UART_DATA_BITS=8, UART_STOP_BITS=1.
  - Function frame_cycles(clks_per_bit, parity) used by both RTL assertions and the testbench.
- Sub-module uart_tx_byte:
  - Contains the baud counter and the START/DATA/(PARITY)/STOP sequence.
  - Handshake: byte_valid/byte_ready, with a byte_done pulse.
- The top q_tx_serializer holds the Q_WIDTH shift register, byte_cnt, IDLE/NEXT control and in_ready/tx_done.

Test Plan (CLKS_PER_BIT=4, Q_WIDTH=256, MSB_BYTE_FIRST=1 unless noted):
- Q=256'h01 (all other bytes 0), in_valid 1 cycle → 32 frames decoded.
  - Bytes 0..30 = 8'h00 and byte 31 = 8'h01.
  - tx_done exactly 32*41=1312 cycles after capture.
  - Tx idle high before and after.
- Q={32{8'hA5}} with MSB_BYTE_FIRST=0 → every decoded byte = 8'hA5.
  - Start bit low for 4 cycles and stop bit high for 4 cycles on each frame.
- Q=256'h...1234 (tail); after capture, hold in_valid=1 with Q=all-ones → in_ready=0 throughout and the second value is never captured.
  - Decoded stream matches the first value only.
- Assert reset=0 mid-way through byte 5's DATA phase → Tx=1, busy=0, in_ready=1 within the same cycle.
  - After release, a new Q=256'hFF transmits cleanly from byte 0.
- Pulse in_valid on the tx_done cycle, then again 1 cycle later.
  - First pulse ignored.
  - Second pulse captured; START begins 1 cycle after it.
- With Q_TX_PARITY_EN defined, Q byte 8'h07 → parity bit = 1, frame = 45 cycles.
  - Byte 8'h03 → parity bit = 0.

Source files
------------

// File: rtl/q_tx_pkg.sv
// Shared types and framing helpers for the result serializer.
// Q_TX_PARITY_EN adds an even-parity bit (8E1) to every UART frame.
package q_tx_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StStop   = 3'd3,
    StNext   = 3'd4
`ifdef Q_TX_PARITY_EN
    , StParity = 3'd5
`endif
  } q_tx_state_e;

  // Cycles per byte on the line, including the one-cycle NEXT gap.
  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                               input bit          parity);
    return (1 + UART_DATA_BITS + (parity ? 32'd1 : 32'd0) + UART_STOP_BITS) * clks_per_bit
           + 1;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One UART frame per accepted byte: START, DATA (LSB first), optional PARITY, STOP.
// Q_TX_PARITY_EN inserts the even-parity bit. i_byte must stay stable until o_byte_done.
module uart_tx_byte
  import q_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  input  logic [7:0] i_byte,
  output logic       o_byte_done,
  output logic       o_tx
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  q_tx_state_e      r_state, w_state_d;
  logic [BaudW-1:0] r_baud, w_baud_d;
  logic [2:0]       r_bit, w_bit_d;
  logic             w_wrap;

  assign w_wrap = (r_baud == BaudLast);

  always_comb begin
    w_state_d    = r_state;
    w_baud_d     = w_wrap ? '0 : r_baud + 1'b1;
    w_bit_d      = r_bit;
    o_tx         = 1'b1;
    o_byte_ready = 1'b0;
    o_byte_done  = 1'b0;
    case (r_state)
      StIdle: begin
        o_byte_ready = 1'b1;
        w_baud_d     = '0;
        if (i_byte_valid) w_state_d = StStart;
      end
      StStart: begin
        o_tx = 1'b0;
        if (w_wrap) begin
          w_state_d = StData;
          w_bit_d   = '0;
        end
      end
      StData: begin
        o_tx = i_byte[r_bit];
        if (w_wrap) begin
          w_bit_d = r_bit + 1'b1;
`ifdef Q_TX_PARITY_EN
          if (r_bit == 3'd7) w_state_d = StParity;
`else
          if (r_bit == 3'd7) w_state_d = StStop;
`endif
        end
      end
`ifdef Q_TX_PARITY_EN
      StParity: begin
        o_tx = ^i_byte;
        if (w_wrap) w_state_d = StStop;
      end
`endif
      StStop: begin
        if (w_wrap) begin
          w_state_d   = StIdle;
          o_byte_done = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_d;
      r_baud  <= w_baud_d;
      r_bit   <= w_bit_d;
    end
  end

endmodule

// File: rtl/q_tx_serializer.sv
// Captures a Q_WIDTH result and sends it as Q_WIDTH/8 UART bytes, then pulses tx_done.
// Q_TX_PARITY_EN switches every byte to 8E1 framing.
module q_tx_serializer
  import q_tx_pkg::*;
#(
  parameter int unsigned Q_WIDTH        = 256,
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter bit          MSB_BYTE_FIRST = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [Q_WIDTH-1:0] Q,
  output logic               in_ready,
  output logic               Tx,
  output logic               busy,
  output logic               tx_done
);

  localparam int unsigned NBytes = Q_WIDTH / 8;
  localparam int unsigned CntW   = (NBytes > 1) ? $clog2(NBytes) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NBytes - 1);
`ifdef Q_TX_PARITY_EN
  localparam bit Parity = 1'b1;
`else
  localparam bit Parity = 1'b0;
`endif
  localparam int unsigned FrameLen = frame_cycles(CLKS_PER_BIT, Parity);

  // StStart here spans the whole frame; the byte sender tracks the bit phases.
  q_tx_state_e      r_state, w_state_d;
  logic [Q_WIDTH-1:0] r_shift;
  logic [CntW-1:0]  r_byte_cnt;
  logic             w_load, w_advance, w_byte_valid, w_byte_ready, w_byte_done;
  logic [7:0]       w_cur_byte;
  int unsigned      r_frame_len;

  assign w_cur_byte = MSB_BYTE_FIRST ? r_shift[Q_WIDTH-1 -: 8] : r_shift[7:0];

  always_comb begin
    w_state_d    = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_byte_valid = 1'b0;
    case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_load       = 1'b1;
          w_byte_valid = 1'b1;
          w_state_d    = StStart;
        end
      end
      StStart: if (w_byte_done) w_state_d = StNext;
      StNext: begin
        w_advance = 1'b1;
        if (r_byte_cnt == CntLast) begin
          w_state_d = StIdle;
        end else begin
          w_byte_valid = 1'b1;
          w_state_d    = StStart;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_shift    <= Q;
        r_byte_cnt <= '0;
      end else if (w_advance) begin
        r_shift    <= MSB_BYTE_FIRST ? (r_shift << 8) : (r_shift >> 8);
        r_byte_cnt <= (r_byte_cnt == CntLast) ? '0 : r_byte_cnt + 1'b1;
      end
    end
  end

  assign busy     = (r_state != StIdle);
  assign in_ready = !busy;
  assign tx_done  = (r_state == StNext) && (r_byte_cnt == CntLast);

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clock        (clock),
    .reset        (reset),
    .i_byte_valid (w_byte_valid),
    .o_byte_ready (w_byte_ready),
    .i_byte       (w_cur_byte),
    .o_byte_done  (w_byte_done),
    .o_tx         (Tx)
  );

  // Frame-length self-check: the sender must finish exactly one NEXT cycle short of a frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_frame_len <= 0;
    else if (r_state == StStart) r_frame_len <= r_frame_len + 1;
    else r_frame_len <= 0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if (w_byte_done) assert (r_frame_len == FrameLen - 2);
      if (w_byte_valid) assert (w_byte_ready);
    end
  end

endmodule

// File: tb/tb_q_tx_serializer.sv
// Bench for q_tx_serializer: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against an arithmetic line model, plus decoded-byte expectations.
module tb_q_tx_serializer;
  import q_tx_pkg::*;

  localparam int QW  = 256;
  localparam int CPB = 4;
`ifdef Q_TX_PARITY_EN
  localparam bit Par      = 1'b1;
  localparam int TotalLit = 1440;
`else
  localparam bit Par      = 1'b0;
  localparam int TotalLit = 1312;
`endif
  localparam int F     = int'(frame_cycles(CPB, Par));
  localparam int Total = (QW / 8) * F;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [QW-1:0] q_in;
  logic          rdy[2], tx[2], bsy[2], dn[2];

  always #5 clk = ~clk;

  q_tx_serializer #(.Q_WIDTH(QW), .CLKS_PER_BIT(CPB), .MSB_BYTE_FIRST(1'b1)) u_dut_msb (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .Q(q_in),
    .in_ready(rdy[0]), .Tx(tx[0]), .busy(bsy[0]), .tx_done(dn[0])
  );

  q_tx_serializer #(.Q_WIDTH(QW), .CLKS_PER_BIT(CPB), .MSB_BYTE_FIRST(1'b0)) u_dut_lsb (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .Q(q_in),
    .in_ready(rdy[1]), .Tx(tx[1]), .busy(bsy[1]), .tx_done(dn[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cap = 0;
  int lat = 0;
  bit cmp_en = 1'b0;
  logic [7:0] got[32];
  logic       gotp[32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event did not occur within its bound at cycle %0d", name, cyc);
  endtask

  // Line model: t counts cycles since capture; the line is fixed by position within a frame.
  logic [QW-1:0] m_val;
  int            m_t;
  bit            m_act;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_act <= 1'b0;
    else if (m_act) begin
      if (m_t == Total - 1) m_act <= 1'b0;
      else m_t <= m_t + 1;
    end else if (in_valid) begin
      m_act <= 1'b1;
      m_t   <= 0;
      m_val <= q_in;
    end
  end

  function automatic logic exp_tx(input logic [QW-1:0] v, input int t, input bit msb);
    int k, w;
    logic [7:0] b;
    k = t / F;
    w = t % F;
    b = msb ? v[QW-1-8*k -: 8] : v[8*k +: 8];
    if (w < CPB) return 1'b0;
    if (w < 9 * CPB) return b[(w - CPB) / CPB];
    if (Par && w < 10 * CPB) return ^b;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      for (int i = 0; i < 2; i++) begin
        check(i == 0 ? "msb_tx" : "lsb_tx", tx[i], m_act ? exp_tx(m_val, m_t, i == 0) : 1'b1);
        check(i == 0 ? "msb_busy" : "lsb_busy", bsy[i], m_act);
        check(i == 0 ? "msb_ready" : "lsb_ready", rdy[i], !m_act);
        check(i == 0 ? "msb_done" : "lsb_done", dn[i], m_act && (m_t == Total - 1));
      end
    end
  end

  task automatic send(input logic [QW-1:0] v);
    @(posedge clk); #1;
    in_valid = 1'b1;
    q_in     = v;
    cap      = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic decode_frame(input int sel, output logic [7:0] b, output logic pb);
    int n;
    b  = '0;
    pb = 1'b0;
    n  = 0;
    while (tx[sel] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      fail_now("start_bit_wait");
      return;
    end
    repeat (2) @(negedge clk);
    check("start_bit_mid", tx[sel], 1'b0);
    for (int j = 0; j < 8; j++) begin
      repeat (CPB) @(negedge clk);
      b[j] = tx[sel];
    end
    if (Par) begin
      repeat (CPB) @(negedge clk);
      pb = tx[sel];
    end
    repeat (CPB) @(negedge clk);
    check("stop_bit_mid", tx[sel], 1'b1);
  endtask

  task automatic decode_all(input int sel);
    for (int k = 0; k < 32; k++) decode_frame(sel, got[k], gotp[k]);
  endtask

  task automatic wait_done(input int sel);
    int n;
    n = 0;
    while (dn[sel] !== 1'b1 && n < F + 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= F + 10) fail_now("tx_done_wait");
    lat = cyc - cap;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    q_in     = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_tx", tx[i], 1'b1);
      check("reset_ready", rdy[i], 1'b1);
      check("reset_busy", bsy[i], 1'b0);
      check("reset_done", dn[i], 1'b0);
    end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_tx_before", tx[0], 1'b1);

    // Single low byte, MSB-first: it arrives last.
    send(256'h01);
    check("ready_drop", rdy[0], 1'b0);
    decode_all(0);
    for (int k = 0; k < 32; k++) check($sformatf("t1_byte%0d", k), got[k], k == 31 ? 8'h01 : 8'h00);
    wait_done(0);
    check("t1_latency", lat, TotalLit);
    repeat (5) @(negedge clk);
    check("idle_tx_after", tx[0], 1'b1);
    check("idle_ready_after", rdy[0], 1'b1);

    // Uniform pattern on the LSB-first instance.
    send({32{8'hA5}});
    decode_all(1);
    for (int k = 0; k < 32; k++) check($sformatf("t2_byte%0d", k), got[k], 8'hA5);
    wait_done(1);
    check("t2_latency", lat, TotalLit);

    // Producer keeps in_valid high with a new value; only the first is sent.
    @(posedge clk); #1;
    in_valid = 1'b1;
    q_in     = 256'h1234;
    cap      = cyc;
    @(posedge clk); #1;
    q_in = '1;
    check("t3_ready_low", rdy[0], 1'b0);
    decode_all(0);
    for (int k = 0; k < 32; k++)
      check($sformatf("t3_byte%0d", k), got[k], k == 30 ? 8'h12 : (k == 31 ? 8'h34 : 8'h00));
    wait_done(0);
    check("t3_latency", lat, TotalLit);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_no_second_capture", bsy[0], 1'b0);

    // Reset during byte 5, data bit 2.
    send(256'hDEADBEEF_CAFEF00D_0123_4567_89AB_CDEF);
    repeat (5 * F + 3 * CPB) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_mid_tx", tx[i], 1'b1);
      check("rst_mid_busy", bsy[i], 1'b0);
      check("rst_mid_ready", rdy[i], 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(256'hFF);
    decode_all(0);
    for (int k = 0; k < 32; k++) check($sformatf("t4_byte%0d", k), got[k], k == 31 ? 8'hFF : 8'h00);
    wait_done(0);
    check("t4_latency", lat, TotalLit);

    // in_valid on the tx_done cycle is ignored; the next cycle is accepted.
    send(256'hAB);
    repeat (Total - 1) @(posedge clk);
    #1;
    check("t5_done_cycle", dn[0], 1'b1);
    in_valid = 1'b1;
    q_in     = 256'hA1;
    @(posedge clk); #1;
    check("t5_first_ignored", rdy[0], 1'b1);
    q_in = 256'hB2;
    cap  = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_start_next_cycle", tx[0], 1'b0);
    check("t5_busy", bsy[0], 1'b1);
    decode_all(0);
    check("t5_byte30", got[30], 8'h00);
    check("t5_byte31", got[31], 8'hB2);
    wait_done(0);
    check("t5_latency", lat, TotalLit);

`ifdef Q_TX_PARITY_EN
    send(256'h0307);
    decode_all(0);
    check("par_byte30", got[30], 8'h03);
    check("par_bit30", gotp[30], 1'b0);
    check("par_byte31", got[31], 8'h07);
    check("par_bit31", gotp[31], 1'b1);
    check("par_bit0", gotp[0], 1'b0);
    wait_done(0);
    check("par_latency", lat, 32 * 45);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
